// File: rtl/loader_pkg.sv
// Shared types and sizing for the instruction-memory program loader.
package loader_pkg;
  typedef enum logic [1:0] {RUN, LOAD, FLUSH, DONE} load_state_t;
  localparam int BYTES_PER_WORD = 4;
  localparam int BYTE_W = 8;
  localparam int WORD_W = BYTES_PER_WORD * BYTE_W;
endpackage

// File: rtl/byte_packer.sv
// Packs loader bytes big-endian into 32-bit words; word/word_vld are combinational
// in the cycle the 4th byte (or a flush of a partial word) is presented.
module byte_packer
  import loader_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_vld,
  input  logic [BYTE_W-1:0] byte_dat,
  input  logic              flush,
  output logic [WORD_W-1:0] word,
  output logic              word_vld,
  output logic              partial
);

  logic [WORD_W-1:0] sh_q, sh_d;
  logic [1:0]        cnt_q, cnt_d;

  always_comb begin
    sh_d     = sh_q;
    cnt_d    = cnt_q;
    word     = {sh_q[WORD_W-BYTE_W-1:0], byte_dat};
    word_vld = 1'b0;
    if (clear) begin
      sh_d  = '0;
      cnt_d = '0;
    end else if (flush) begin
      // Left-justify the bytes collected so far; unfilled low bytes read as zero.
      word_vld = (cnt_q != 2'd0);
      case (cnt_q)
        2'd1:    word = {sh_q[BYTE_W-1:0],   {(3*BYTE_W){1'b0}}};
        2'd2:    word = {sh_q[2*BYTE_W-1:0], {(2*BYTE_W){1'b0}}};
        2'd3:    word = {sh_q[3*BYTE_W-1:0], {BYTE_W{1'b0}}};
        default: word = '0;
      endcase
      sh_d  = '0;
      cnt_d = '0;
    end else if (byte_vld) begin
      sh_d     = {sh_q[WORD_W-BYTE_W-1:0], byte_dat};
      cnt_d    = cnt_q + 2'd1;
      word_vld = (cnt_q == 2'd3);
    end
    partial = (cnt_d != 2'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else begin
      sh_q  <= sh_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/prog_load_ctrl.sv
// Loader sequencer: owns the instruction-memory port while loading, one registered
// write per packed word, and holds the core off until the load completes.
module prog_load_ctrl
  import loader_pkg::*;
#(
  parameter int INST_MEM_WIDTH = 2
) (
  input  logic                      CLK,
  input  logic                      reset,
  input  logic [BYTE_W-1:0]         rx_data,
  input  logic                      rx_valid,
  input  logic                      load_start,
  input  logic                      load_end,
  input  logic [INST_MEM_WIDTH-1:0] fetch_pc,
  output logic [INST_MEM_WIDTH-1:0] mem_addr,
  output logic [WORD_W-1:0]         mem_wdata,
  output logic                      mem_we,
  output logic                      inst_enable,
  output logic                      load_busy,
  output logic [INST_MEM_WIDTH:0]   word_count,
  output logic                      overflow_err
);

  localparam int DEPTH = 2 ** INST_MEM_WIDTH;
  localparam logic [INST_MEM_WIDTH:0] FULL_CNT = (INST_MEM_WIDTH + 1)'(DEPTH);

  load_state_t                 state_q, state_d;
  logic [INST_MEM_WIDTH:0]     ptr_q, ptr_d;
  logic [INST_MEM_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [WORD_W-1:0]           wdata_q, wdata_d;
  logic                        mem_we_q, mem_we_d;
  logic                        inst_en_q, inst_en_d;
  logic                        busy_q, busy_d;
  logic                        ovf_q, ovf_d;

  logic              pk_byte_vld, pk_flush, pk_word_vld, pk_partial;
  logic [WORD_W-1:0] pk_word;

  assign pk_byte_vld = (state_q == LOAD) && rx_valid && !load_start;
  assign pk_flush    = (state_q == FLUSH) && !load_start;

  byte_packer u_packer (
    .clk      (CLK),
    .reset    (reset),
    .clear    (load_start),
    .byte_vld (pk_byte_vld),
    .byte_dat (rx_data),
    .flush    (pk_flush),
    .word     (pk_word),
    .word_vld (pk_word_vld),
    .partial  (pk_partial)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_addr_d = wr_addr_q;
    wdata_d   = wdata_q;
    mem_we_d  = 1'b0;
    ovf_d     = ovf_q;
    if (load_start) begin
      state_d = LOAD;
      ptr_d   = '0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        RUN:     state_d = RUN;
        LOAD:    if (load_end) state_d = pk_partial ? FLUSH : DONE;
        FLUSH:   state_d = DONE;
        DONE:    state_d = RUN;
        default: state_d = RUN;
      endcase
      // ptr doubles as the word count, so it saturates at depth rather than wrapping.
      if (pk_word_vld) begin
        if (ptr_q == FULL_CNT) begin
          ovf_d = 1'b1;
        end else begin
          mem_we_d  = 1'b1;
          wdata_d   = pk_word;
          wr_addr_d = ptr_q[INST_MEM_WIDTH-1:0];
          ptr_d     = ptr_q + 1'b1;
        end
      end
    end
    inst_en_d = (state_d == RUN);
    busy_d    = (state_d != RUN);
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q   <= RUN;
      ptr_q     <= '0;
      wr_addr_q <= '0;
      wdata_q   <= '0;
      mem_we_q  <= 1'b0;
      inst_en_q <= 1'b1;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      wr_addr_q <= wr_addr_d;
      wdata_q   <= wdata_d;
      mem_we_q  <= mem_we_d;
      inst_en_q <= inst_en_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
    end
  end

  // ptr has already advanced during the write cycle, so the write shows its latched address.
  assign mem_addr     = (state_q == RUN) ? fetch_pc :
                        (mem_we_q ? wr_addr_q : ptr_q[INST_MEM_WIDTH-1:0]);
  assign mem_wdata    = wdata_q;
  assign mem_we       = mem_we_q;
  assign inst_enable  = inst_en_q;
  assign load_busy    = busy_q;
  assign word_count   = ptr_q;
  assign overflow_err = ovf_q;

endmodule
